// File: rtl/cp0_int_unit.sv
// cp0_int_unit: coprocessor-0 exception/interrupt sequencer for the multicycle
// MIPS core. Owns Status (12), Cause (13) and EPC (14), arbitrates overflow,
// syscall and NUM_IRQ level interrupts, and runs the trap entry sequence
// (save EPC, save Cause, set EXL, redirect PC). Also services mtc0/mfc0/eret.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   irq             - level interrupt requests (live copy shown in Cause.IP)
//   inst_boundary   - main FSM at fetch boundary; interrupts may be taken
//   pc_cur          - PC saved into EPC when a trap is accepted
//   syscall         - one-cycle pulse, ExcCode 8
//   overflow        - one-cycle pulse, ExcCode 12
//   eret            - one-cycle pulse, return from exception
//   cp0_we/addr/wdata - mtc0 write port
//   cp0_rdata       - mfc0 read data, combinational from cp0_addr
//   busy            - sequencer not idle; main FSM stalls
//   pc_redirect     - one-cycle pulse, PC loads pc_target
//   pc_target       - redirect address (holds last value)
//   state_out       - current sequencer state
//
// Handshake: the pulses (syscall, overflow, eret) are only sampled while the
// sequencer is idle; the main FSM holds off new pulses while busy is high and
// reacts to pc_redirect in the single cycle it is asserted.
module cp0_int_unit #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0004
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               inst_boundary,
    input  logic [31:0]        pc_cur,
    input  logic               syscall,
    input  logic               overflow,
    input  logic               eret,
    input  logic               cp0_we,
    input  logic [4:0]         cp0_addr,
    input  logic [31:0]        cp0_wdata,
    output logic [31:0]        cp0_rdata,
    output logic               busy,
    output logic               pc_redirect,
    output logic [31:0]        pc_target,
    output logic [2:0]         state_out
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SAVE_EPC   = 3'd1,
        ST_SAVE_CAUSE = 3'd2,
        ST_SET_EXL    = 3'd3,
        ST_JUMP       = 3'd4,
        ST_ERET_OUT   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic               ie_q, ie_d;
    logic               exl_q, exl_d;
    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [31:0]        epc_q, epc_d;
    logic [31:0]        hold_pc_q, hold_pc_d;
    logic [4:0]         hold_code_q, hold_code_d;
    logic               pc_redirect_q, pc_redirect_d;
    logic [31:0]        pc_target_q, pc_target_d;
    logic               irq_take;

    assign irq_take = ie_q && !exl_q && inst_boundary && ((irq & im_q) != '0);

    always_comb begin
        state_d       = state_q;
        ie_d          = ie_q;
        exl_d         = exl_q;
        im_d          = im_q;
        exc_code_d    = exc_code_q;
        epc_d         = epc_q;
        hold_pc_d     = hold_pc_q;
        hold_code_d   = hold_code_q;
        pc_redirect_d = 1'b0;
        pc_target_d   = pc_target_q;

        // mtc0 is applied first so that any sequencer update below, made on
        // the same edge, overrides it. Cause is read-only from software.
        if (cp0_we) begin
            case (cp0_addr)
                5'd12: begin
                    ie_d  = cp0_wdata[0];
                    exl_d = cp0_wdata[1];
                    im_d  = cp0_wdata[8 +: NUM_IRQ];
                end
                5'd14:   epc_d = cp0_wdata;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                // Trap acceptance beats eret; the eret is simply dropped.
                if (overflow || syscall || irq_take) begin
                    hold_pc_d   = pc_cur;
                    hold_code_d = overflow ? 5'd12 : (syscall ? 5'd8 : 5'd0);
                    state_d     = ST_SAVE_EPC;
                end else if (eret) begin
                    exl_d         = 1'b0;
                    pc_redirect_d = 1'b1;
                    pc_target_d   = epc_q;
                    state_d       = ST_ERET_OUT;
                end
            end
            ST_SAVE_EPC: begin
                // A nested exception (EXL already set) must keep the original
                // return address.
                if (!exl_q) begin
                    epc_d = hold_pc_q;
                end
                state_d = ST_SAVE_CAUSE;
            end
            ST_SAVE_CAUSE: begin
                exc_code_d = hold_code_q;
                state_d    = ST_SET_EXL;
            end
            ST_SET_EXL: begin
                // Redirect is registered on entry to JUMP so it is high for
                // exactly the JUMP cycle.
                exl_d         = 1'b1;
                pc_redirect_d = 1'b1;
                pc_target_d   = HANDLER_ADDR;
                state_d       = ST_JUMP;
            end
            ST_JUMP:     state_d = ST_IDLE;
            ST_ERET_OUT: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ie_q          <= 1'b0;
            exl_q         <= 1'b0;
            im_q          <= '0;
            exc_code_q    <= 5'd0;
            epc_q         <= 32'd0;
            hold_pc_q     <= 32'd0;
            hold_code_q   <= 5'd0;
            pc_redirect_q <= 1'b0;
            pc_target_q   <= 32'd0;
        end else begin
            state_q       <= state_d;
            ie_q          <= ie_d;
            exl_q         <= exl_d;
            im_q          <= im_d;
            exc_code_q    <= exc_code_d;
            epc_q         <= epc_d;
            hold_pc_q     <= hold_pc_d;
            hold_code_q   <= hold_code_d;
            pc_redirect_q <= pc_redirect_d;
            pc_target_q   <= pc_target_d;
        end
    end

    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_addr)
            5'd12: begin
                cp0_rdata[0]            = ie_q;
                cp0_rdata[1]            = exl_q;
                cp0_rdata[8 +: NUM_IRQ] = im_q;
            end
            5'd13: begin
                cp0_rdata[6:2]          = exc_code_q;
                cp0_rdata[8 +: NUM_IRQ] = irq;
            end
            5'd14:   cp0_rdata = epc_q;
            default: cp0_rdata = 32'd0;
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign pc_redirect = pc_redirect_q;
    assign pc_target   = pc_target_q;
    assign state_out   = state_q;

endmodule
